cover_toggle_drain: RTL and testbench

Sequencing front end for 64-bit toggle-coverage vectors in simulation builds. Captures per-cycle cover hits into a sticky pending mask, arbitrates round-robin among pending points, and emits one absolute cover index per handshake to a downstream collector (DPI bridge or on-chip coverage buffer). Optional de-duplication reports each point at most once until cleared, which lets slow consumers drain bursty hit vectors without losing points.

---
 rtl/cover_toggle_drain_if.sv | 19 +
 rtl/cover_toggle_drain.sv | 160 ++++++++++++++++
 tb/tb_cover_toggle_drain.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cover_toggle_drain_if.sv
// Drain-side handshake for cover_toggle_drain: one absolute cover index per
// accepted transfer.
interface cover_toggle_drain_if;
  logic        out_valid;
  logic [63:0] out_index;
  logic        out_ready;

  modport master (
    output out_valid,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    output out_ready
  );
endinterface

// File: rtl/cover_toggle_drain.sv
// Sticky capture of 64 per-cycle cover hits, round-robin selection among
// pending points, and one absolute cover index offered per handshake.
module cover_toggle_drain #(
  parameter logic [63:0] COVER_INDEX = 64'd0,
  parameter logic [63:0] COVER_TOTAL = 64'd10906
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [63:0]                 valid,
  input  logic                        dedup_en,
  input  logic                        clear,
  output logic                        busy,
  output logic [6:0]                  covered_cnt,
  output logic [15:0]                 coalesce_cnt,
  cover_toggle_drain_if.master        drain
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  state_t      state_r;
  logic [63:0] pending_r;
  logic [63:0] covered_r;
  logic [5:0]  rr_ptr_r;
  logic        out_valid_r;
  logic [63:0] out_index_r;
  logic [6:0]  covered_cnt_r;
  logic [15:0] coalesce_cnt_r;

  logic [6:0]  pick_s;
  logic [5:0]  sel_s;
  logic        handshake_s;
  logic        load_s;
  logic [63:0] loaded_bit_s;
  logic [63:0] covered_next_s;
  logic [63:0] new_s;
  logic [63:0] coal_s;
  logic [16:0] coal_sum_s;
  logic [63:0] sel_index_s;

  // Returns {found, index} of the first set bit scanning upward from ptr,
  // wrapping 63 -> 0; the downward loop lets the nearest candidate win.
  function automatic logic [6:0] rr_pick(input logic [63:0] vec, input logic [5:0] ptr);
    logic [6:0] res;
    logic [5:0] idx;
    res = 7'd0;
    for (int i = 63; i >= 0; i--) begin
      idx = ptr + i[5:0];
      if (vec[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 0; i < 64; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  // Selection, load decision and hit masking for the current cycle.
  always_comb begin
    pick_s       = rr_pick(pending_r, rr_ptr_r);
    sel_s        = pick_s[5:0];
    handshake_s  = out_valid_r & drain.out_ready;
    load_s       = 1'b0;
    case (state_r)
      ST_IDLE:  load_s = ~clear & pick_s[6];
      ST_OFFER: load_s = ~clear & pick_s[6] & handshake_s;
      default:  load_s = 1'b0;
    endcase
    if (load_s) begin
      loaded_bit_s = 64'd1 << sel_s;
    end else begin
      loaded_bit_s = 64'd0;
    end
    if (load_s && dedup_en) begin
      covered_next_s = covered_r | loaded_bit_s;
    end else begin
      covered_next_s = covered_r;
    end
    if (dedup_en) begin
      new_s = valid & ~covered_next_s;
    end else begin
      new_s = valid;
    end
    coal_s      = new_s & pending_r & ~loaded_bit_s;
    coal_sum_s  = {1'b0, coalesce_cnt_r} + {10'd0, popcount64(coal_s)};
    sel_index_s = COVER_INDEX + {58'd0, sel_s};
  end

  // Pending/covered bookkeeping, counters and the offer FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      pending_r      <= 64'd0;
      covered_r      <= 64'd0;
      rr_ptr_r       <= 6'd0;
      out_valid_r    <= 1'b0;
      out_index_r    <= 64'd0;
      covered_cnt_r  <= 7'd0;
      coalesce_cnt_r <= 16'd0;
    end else begin
      if (clear) begin
        pending_r      <= 64'd0;
        covered_r      <= 64'd0;
        covered_cnt_r  <= 7'd0;
        coalesce_cnt_r <= 16'd0;
      end else begin
        pending_r      <= (pending_r & ~loaded_bit_s) | new_s;
        covered_r      <= covered_next_s;
        coalesce_cnt_r <= coal_sum_s[16] ? 16'hFFFF : coal_sum_s[15:0];
        // A point already covered before a dedup toggle is not counted twice.
        if (load_s && dedup_en && !covered_r[sel_s]) begin
          covered_cnt_r <= covered_cnt_r + 7'd1;
        end
        if (load_s) begin
          rr_ptr_r <= sel_s + 6'd1;
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (load_s) begin
            state_r     <= ST_OFFER;
            out_valid_r <= 1'b1;
            out_index_r <= sel_index_s;
          end
        end
        ST_OFFER: begin
          if (handshake_s) begin
            if (load_s) begin
              out_index_r <= sel_index_s;
            end else begin
              state_r     <= ST_IDLE;
              out_valid_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = out_valid_r | (|pending_r);
  assign covered_cnt     = covered_cnt_r;
  assign coalesce_cnt    = coalesce_cnt_r;
  assign drain.out_valid = out_valid_r;
  assign drain.out_index = out_index_r;

endmodule

// File: tb/tb_cover_toggle_drain.sv
// Directed bench for cover_toggle_drain: vector table for single-hit and
// coalescing behaviour, hand-written sequences for multi-cycle corners.
module tb_cover_toggle_drain;

  localparam logic [63:0] CIDX = 64'd100;

  logic        clock;
  logic        reset;
  logic [63:0] valid;
  logic        dedup_en;
  logic        clear;
  logic        busy;
  logic [6:0]  covered_cnt;
  logic [15:0] coalesce_cnt;

  int n_cmp;
  int n_fail;

  cover_toggle_drain_if drain_bus ();

  cover_toggle_drain #(
    .COVER_INDEX (CIDX),
    .COVER_TOTAL (64'd10906)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .valid        (valid),
    .dedup_en     (dedup_en),
    .clear        (clear),
    .busy         (busy),
    .covered_cnt  (covered_cnt),
    .coalesce_cnt (coalesce_cnt),
    .drain        (drain_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] vin;
    logic        ded;
    logic        clr;
    logic        rdy;
    logic        e_ov;
    logic [63:0] e_idx;
    logic        e_busy;
    logic [6:0]  e_cov;
    logic [15:0] e_coal;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ov"}, {63'd0, drain_bus.out_valid}, 64'd0);
    chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    valid  = 64'd0;
    dedup_en = 1'b1;
    clear  = 1'b0;
    drain_bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_ov", {63'd0, drain_bus.out_valid}, 64'd0);
    chk("rst_idx", drain_bus.out_index, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cov", {57'd0, covered_cnt}, 64'd0);
    chk("rst_coal", {48'd0, coalesce_cnt}, 64'd0);
    reset = 1'b0;

    // Single hit on bit5 (re-hit during its load is dropped), then clear;
    // then bit7 held 5 cycles with dedup off and backpressure.
    tbl[0]  = '{64'h20, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0,   1'b1, 7'd0, 16'd0};
    tbl[1]  = '{64'h20, 1'b1, 1'b0, 1'b1, 1'b1, 64'd105, 1'b1, 7'd1, 16'd0};
    tbl[2]  = '{64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 64'd105, 1'b0, 7'd1, 16'd0};
    tbl[3]  = '{64'h0,  1'b1, 1'b1, 1'b1, 1'b0, 64'd105, 1'b0, 7'd0, 16'd0};
    tbl[4]  = '{64'h80, 1'b0, 1'b0, 1'b0, 1'b0, 64'd105, 1'b1, 7'd0, 16'd0};
    tbl[5]  = '{64'h80, 1'b0, 1'b0, 1'b0, 1'b1, 64'd107, 1'b1, 7'd0, 16'd0};
    tbl[6]  = '{64'h80, 1'b0, 1'b0, 1'b0, 1'b1, 64'd107, 1'b1, 7'd0, 16'd1};
    tbl[7]  = '{64'h80, 1'b0, 1'b0, 1'b0, 1'b1, 64'd107, 1'b1, 7'd0, 16'd2};
    tbl[8]  = '{64'h80, 1'b0, 1'b0, 1'b0, 1'b1, 64'd107, 1'b1, 7'd0, 16'd3};
    tbl[9]  = '{64'h0,  1'b0, 1'b0, 1'b1, 1'b1, 64'd107, 1'b1, 7'd0, 16'd3};
    tbl[10] = '{64'h0,  1'b0, 1'b0, 1'b1, 1'b0, 64'd107, 1'b0, 7'd0, 16'd3};
    tbl[11] = '{64'h0,  1'b0, 1'b1, 1'b1, 1'b0, 64'd107, 1'b0, 7'd0, 16'd0};

    for (int i = 0; i < 12; i++) begin
      valid    = tbl[i].vin;
      dedup_en = tbl[i].ded;
      clear    = tbl[i].clr;
      drain_bus.out_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_ov", i), {63'd0, drain_bus.out_valid}, {63'd0, tbl[i].e_ov});
      chk($sformatf("vec%0d_idx", i), drain_bus.out_index, tbl[i].e_idx);
      chk($sformatf("vec%0d_busy", i), {63'd0, busy}, {63'd0, tbl[i].e_busy});
      chk($sformatf("vec%0d_cov", i), {57'd0, covered_cnt}, {57'd0, tbl[i].e_cov});
      chk($sformatf("vec%0d_coal", i), {48'd0, coalesce_cnt}, {48'd0, tbl[i].e_coal});
    end
    clear = 1'b0;

    // Full burst from rr_ptr=0: 64 back-to-back indices, then masked repeat.
    reset = 1'b1;
    step();
    reset = 1'b0;
    dedup_en = 1'b1;
    drain_bus.out_ready = 1'b1;
    valid = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    valid = 64'd0;
    chk("burst_pend_busy", {63'd0, busy}, 64'd1);
    step();
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("burst%0d_ov", k), {63'd0, drain_bus.out_valid}, 64'd1);
      chk($sformatf("burst%0d_idx", k), drain_bus.out_index, CIDX + 64'(k));
      chk($sformatf("burst%0d_cov", k), {57'd0, covered_cnt}, 64'(k + 1));
      step();
    end
    chk_idle("burst_end");
    chk("burst_cov64", {57'd0, covered_cnt}, 64'd64);
    valid = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    valid = 64'd0;
    for (int k = 0; k < 3; k++) begin
      chk_idle($sformatf("repeat%0d", k));
      step();
    end

    // Backpressure with pending {3,60}, then rr_ptr wrap with {2,62}.
    clear = 1'b1;
    step();
    clear = 1'b0;
    drain_bus.out_ready = 1'b0;
    valid = 64'h1000_0000_0000_0008;
    step();
    valid = 64'd0;
    step();
    chk("bp_first", drain_bus.out_index, CIDX + 64'd3);
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("bp_hold%0d_ov", k), {63'd0, drain_bus.out_valid}, 64'd1);
      chk($sformatf("bp_hold%0d_idx", k), drain_bus.out_index, CIDX + 64'd3);
    end
    drain_bus.out_ready = 1'b1;
    step();
    chk("bp_next_ov", {63'd0, drain_bus.out_valid}, 64'd1);
    chk("bp_next_idx", drain_bus.out_index, CIDX + 64'd60);
    step();
    chk_idle("bp_done");
    drain_bus.out_ready = 1'b0;
    valid = 64'h4000_0000_0000_0004;
    step();
    valid = 64'd0;
    step();
    chk("wrap_first", drain_bus.out_index, CIDX + 64'd62);
    drain_bus.out_ready = 1'b1;
    step();
    chk("wrap_second_ov", {63'd0, drain_bus.out_valid}, 64'd1);
    chk("wrap_second", drain_bus.out_index, CIDX + 64'd2);
    step();
    chk_idle("wrap_done");

    // Clear while +9 is offered and {1,2} are pending.
    clear = 1'b1;
    step();
    clear = 1'b0;
    drain_bus.out_ready = 1'b0;
    valid = 64'h200;
    step();
    valid = 64'd0;
    step();
    chk("clr_offer", drain_bus.out_index, CIDX + 64'd9);
    valid = 64'h6;
    step();
    valid = 64'd0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_ov_held", {63'd0, drain_bus.out_valid}, 64'd1);
    chk("clr_idx_held", drain_bus.out_index, CIDX + 64'd9);
    chk("clr_cov", {57'd0, covered_cnt}, 64'd0);
    chk("clr_coal", {48'd0, coalesce_cnt}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("clr_hold%0d", k), drain_bus.out_index, CIDX + 64'd9);
    end
    drain_bus.out_ready = 1'b1;
    step();
    chk_idle("clr_accept");
    valid = 64'h200;
    step();
    valid = 64'd0;
    step();
    chk("clr_rehit_ov", {63'd0, drain_bus.out_valid}, 64'd1);
    chk("clr_rehit_idx", drain_bus.out_index, CIDX + 64'd9);
    step();
    chk_idle("clr_rehit_done");

    // Reset in the middle of a drain; rr_ptr sits at 10 here.
    clear = 1'b1;
    step();
    clear = 1'b0;
    valid = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    valid = 64'd0;
    step();
    chk("rmid_0", drain_bus.out_index, CIDX + 64'd10);
    step();
    chk("rmid_1", drain_bus.out_index, CIDX + 64'd11);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmid_ov", {63'd0, drain_bus.out_valid}, 64'd0);
    chk("rmid_idx", drain_bus.out_index, 64'd0);
    chk("rmid_busy", {63'd0, busy}, 64'd0);
    chk("rmid_cov", {57'd0, covered_cnt}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_idle($sformatf("rmid_after%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
